// File: rtl/fb_write_arbiter.sv
// Merges CPU pixel writes and an optional full-screen fill onto a single framebuffer write port.
// Define FB_CLEAR_EN to compile in the fill engine (WAIT/CLEAR states, clear_done, overflow).
module fb_write_arbiter #(
  parameter int RESOLUTION_X   = 400,
  parameter int RESOLUTION_Y   = 300,
  parameter int PALETTE_LENGTH = 256,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         cpu_wr_en,
  input  logic [$clog2(RESOLUTION_X)-1:0]              cpu_wr_pxl_x,
  input  logic [$clog2(RESOLUTION_Y)-1:0]              cpu_wr_pxl_y,
  input  logic [$clog2(PALETTE_LENGTH)-1:0]            cpu_wr_pxl_value,
  input  logic                                         clear_start,
  input  logic [$clog2(PALETTE_LENGTH)-1:0]            clear_value,
  output logic                                         fb_wr_en,
  output logic [$clog2(RESOLUTION_X*RESOLUTION_Y)-1:0] fb_wr_addr,
  output logic [$clog2(PALETTE_LENGTH)-1:0]            fb_wr_data,
  output logic                                         busy,
  output logic                                         clear_done,
  output logic                                         overflow
);
  localparam int PW   = $clog2(PALETTE_LENGTH);
  localparam int AW   = $clog2(RESOLUTION_X*RESOLUTION_Y);
  localparam int EW   = AW + PW;
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int NPIX = RESOLUTION_X * RESOLUTION_Y;

`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CLEAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0} state_t;
`endif

  state_t          r_state, w_state_nxt;
  logic [EW-1:0]   r_fifo [FIFO_DEPTH];
  logic [PTRW-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTRW:0]   r_count;
  logic            r_fb_wr_en;
  logic [AW-1:0]   r_fb_wr_addr;
  logic [PW-1:0]   r_fb_wr_data;

  logic            w_cpu_valid, w_fifo_empty, w_fifo_full;
  logic            w_push, w_push_ok, w_pop, w_out_en;
  logic [AW-1:0]   w_cpu_addr, w_out_addr, w_head_addr;
  logic [PW-1:0]   w_out_data, w_head_data;
  logic [EW-1:0]   w_head;

  // Out-of-range coordinates are filtered here so they never reach the FIFO or overflow logic.
  assign w_cpu_valid  = cpu_wr_en && (32'(cpu_wr_pxl_x) < RESOLUTION_X)
                                  && (32'(cpu_wr_pxl_y) < RESOLUTION_Y);
  assign w_cpu_addr   = AW'(cpu_wr_pxl_y) * AW'(RESOLUTION_X) + AW'(cpu_wr_pxl_x);
  assign w_fifo_empty = (r_count == '0);
  assign w_fifo_full  = (r_count == (PTRW+1)'(FIFO_DEPTH));
  assign w_head       = r_fifo[r_rd_ptr];
  assign w_head_addr  = w_head[EW-1:PW];
  assign w_head_data  = w_head[PW-1:0];
  // A pop in the same cycle frees a slot, so push on a full FIFO still succeeds.
  assign w_push_ok    = w_push && (!w_fifo_full || w_pop);

`ifdef FB_CLEAR_EN
  logic          w_clr_accept, w_fill_last, w_drop;
  logic          r_pending, r_fill_last, r_clear_done, r_overflow;
  logic [AW-1:0] r_fill_addr;
  logic [PW-1:0] r_fill_value;
  assign w_drop = w_push && w_fifo_full && !w_pop;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_out_en    = 1'b0;
    w_out_addr  = w_cpu_addr;
    w_out_data  = cpu_wr_pxl_value;
    w_push      = 1'b0;
    w_pop       = 1'b0;
`ifdef FB_CLEAR_EN
    w_clr_accept = 1'b0;
    w_fill_last  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fifo_empty) begin
          w_out_en = w_cpu_valid;
        end else begin
          w_pop      = 1'b1;
          w_out_en   = 1'b1;
          w_out_addr = w_head_addr;
          w_out_data = w_head_data;
          w_push     = w_cpu_valid;
        end
`ifdef FB_CLEAR_EN
        if (clear_start) begin
          w_clr_accept = 1'b1;
          w_state_nxt  = S_WAIT;
        end
`endif
      end
`ifdef FB_CLEAR_EN
      S_WAIT: begin
        w_push = w_cpu_valid;
        if (w_fifo_empty) begin
          w_state_nxt = S_CLEAR;
        end else begin
          w_pop      = 1'b1;
          w_out_en   = 1'b1;
          w_out_addr = w_head_addr;
          w_out_data = w_head_data;
        end
      end
      S_CLEAR: begin
        w_push     = w_cpu_valid;
        w_out_en   = 1'b1;
        w_out_addr = r_fill_addr;
        w_out_data = r_fill_value;
        if (r_fill_addr == AW'(NPIX - 1)) begin
          w_fill_last = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_fb_wr_en   <= 1'b0;
      r_fb_wr_addr <= '0;
      r_fb_wr_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fb_wr_en <= w_out_en;
      if (w_out_en) begin
        r_fb_wr_addr <= w_out_addr;
        r_fb_wr_data <= w_out_data;
      end
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PTRW{1'b0}}, w_push_ok} - {{PTRW{1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= {w_cpu_addr, cpu_wr_pxl_value};
  end

`ifdef FB_CLEAR_EN
  // clear_done trails the last fill write by one cycle; a reset in between cancels it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= 1'b0;
      r_fill_last  <= 1'b0;
      r_clear_done <= 1'b0;
      r_overflow   <= 1'b0;
      r_fill_addr  <= '0;
    end else begin
      r_fill_last  <= w_fill_last;
      r_clear_done <= r_fill_last;
      if (w_drop) r_overflow <= 1'b1;
      if (w_clr_accept) begin
        r_pending   <= 1'b1;
        r_fill_addr <= '0;
      end else if (r_state == S_CLEAR) begin
        r_fill_addr <= r_fill_addr + 1'b1;
        if (w_fill_last) r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_accept) r_fill_value <= clear_value;
  end

  assign busy       = (r_state != S_IDLE) || !w_fifo_empty || r_pending;
  assign clear_done = r_clear_done;
  assign overflow   = r_overflow;
`else
  logic w_unused_clear;
  assign w_unused_clear = ^{clear_start, clear_value};
  assign busy           = (r_state != S_IDLE) || !w_fifo_empty;
  assign clear_done     = 1'b0;
  assign overflow       = 1'b0;
`endif

  assign fb_wr_en   = r_fb_wr_en;
  assign fb_wr_addr = r_fb_wr_addr;
  assign fb_wr_data = r_fb_wr_data;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter (4x3 screen, 4-entry FIFO); the fill tests
// are built when FB_CLEAR_EN is defined, otherwise the bench checks that clear is ignored.
`timescale 1ns/1ps
module tb_fb_write_arbiter;
  localparam int RX = 4, RY = 3, PL = 256, DEPTH = 4, NPIX = RX * RY;

  logic       clk = 1'b0;
  logic       reset = 1'b0, cpu_wr_en = 1'b0, clear_start = 1'b0;
  logic [1:0] cpu_x = '0, cpu_y = '0;
  logic [7:0] cpu_v = '0, clr_v = '0;
  logic       fb_wr_en, busy, clear_done, overflow;
  logic [3:0] fb_wr_addr;
  logic [7:0] fb_wr_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(
    .RESOLUTION_X(RX), .RESOLUTION_Y(RY), .PALETTE_LENGTH(PL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .cpu_wr_en(cpu_wr_en),
    .cpu_wr_pxl_x(cpu_x), .cpu_wr_pxl_y(cpu_y), .cpu_wr_pxl_value(cpu_v),
    .clear_start(clear_start), .clear_value(clr_v),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .busy(busy), .clear_done(clear_done), .overflow(overflow)
  );

  // Reference model: a pending-write queue plus a fill cursor, advanced once per clock.
  typedef enum {M_IDLE, M_WAIT, M_FILL} mmode_t;
  mmode_t     m_mode = M_IDLE;
  int         q_addr[$];
  int         q_data[$];
  int         m_fill_pos = 0, m_fill_val = 0;
  bit         m_done_next = 1'b0;
  bit         exp_en = 1'b0, exp_busy = 1'b0, exp_done = 1'b0, exp_ovf = 1'b0;
  logic [3:0] exp_addr = '0;
  logic [7:0] exp_data = '0;

  task automatic cyc(input bit r, input bit en, input int px, input int py, input int pv,
                     input bit cs, input int pcv);
    mmode_t m0;
    bit     bypass_ok, emitted;
    reset = r; cpu_wr_en = en; cpu_x = 2'(px); cpu_y = 2'(py); cpu_v = 8'(pv);
    clear_start = cs; clr_v = 8'(pcv);
    if (r) begin
      q_addr.delete(); q_data.delete();
      m_mode = M_IDLE; m_done_next = 1'b0;
      exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_ovf = 1'b0;
    end else begin
      m0 = m_mode;
      bypass_ok = (m0 == M_IDLE) && (q_addr.size() == 0);
      emitted = 1'b0;
      exp_done = m_done_next;
      m_done_next = 1'b0;
      if (m0 == M_FILL) begin
        exp_addr = 4'(m_fill_pos); exp_data = 8'(m_fill_val); emitted = 1'b1;
        m_fill_pos++;
        if (m_fill_pos == NPIX) begin m_mode = M_IDLE; m_done_next = 1'b1; end
      end else if (q_addr.size() > 0) begin
        exp_addr = 4'(q_addr.pop_front()); exp_data = 8'(q_data.pop_front()); emitted = 1'b1;
      end else if (m0 == M_WAIT) begin
        m_mode = M_FILL;
      end
      if (en && px < RX && py < RY) begin
        if (bypass_ok) begin
          exp_addr = 4'(py * RX + px); exp_data = 8'(pv); emitted = 1'b1;
        end else if (q_addr.size() < DEPTH) begin
          q_addr.push_back(py * RX + px); q_data.push_back(pv);
        end else begin
          exp_ovf = 1'b1;
        end
      end
`ifdef FB_CLEAR_EN
      if (cs && m0 == M_IDLE) begin m_mode = M_WAIT; m_fill_pos = 0; m_fill_val = pcv; end
`endif
      exp_en = emitted;
      exp_busy = (m_mode != M_IDLE) || (q_addr.size() > 0);
    end
    @(posedge clk); #1;
    reset = 1'b0; cpu_wr_en = 1'b0; clear_start = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++; if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%b want=0", fb_wr_en); end
    checks++; if (fb_wr_addr !== 4'd0) begin errors++; $display("FAIL rst_addr got=%0d want=0", fb_wr_addr); end
    checks++; if (fb_wr_data !== 8'd0) begin errors++; $display("FAIL rst_data got=%0h want=0", fb_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", clear_done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b want=0", overflow); end
  endtask

  task automatic test_bypass();
    cyc(0, 1, 3, 2, 8'h5A, 0, 0);
    checks++; if (fb_wr_en !== 1'b1) begin errors++; $display("FAIL byp_en got=%b want=1", fb_wr_en); end
    checks++; if (fb_wr_addr !== 4'd11) begin errors++; $display("FAIL byp_addr got=%0d want=11", fb_wr_addr); end
    checks++; if (fb_wr_data !== 8'h5A) begin errors++; $display("FAIL byp_data got=%0h want=5a", fb_wr_data); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL hold_en got=%b want=0", fb_wr_en); end
    checks++; if ({fb_wr_addr, fb_wr_data} !== {4'd11, 8'h5A})
      begin errors++; $display("FAIL hold_val got=%0d/%0h want=11/5a", fb_wr_addr, fb_wr_data); end
  endtask

  task automatic test_out_of_range();
    // Row 3 is off-screen; the column port cannot express an off-screen value at this size.
    cyc(0, 1, 0, 3, 8'hC3, 0, 0);
    checks++; if (fb_wr_en !== 1'b0) begin errors++; $display("FAIL oor_en got=%b want=0", fb_wr_en); end
    checks++; if (fb_wr_addr !== 4'd11) begin errors++; $display("FAIL oor_addr got=%0d want=11", fb_wr_addr); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL oor_ovf got=%b want=0", overflow); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int n;
    cyc(0, 0, 0, 0, 0, 1, 8'h07);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got=%b want=1", busy); end
    n = 0;
    while (fb_wr_en !== 1'b1 && n < 5) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
    checks++; if (n >= 5) begin errors++; $display("FAIL clr_start got=no_write want=write_within_5"); end
    for (int i = 0; i < NPIX; i++) begin
      checks++;
      if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 4'(i), 8'h07})
        begin errors++; $display("FAIL clr_px%0d got=%b/%0d/%0h want=1/%0d/07", i, fb_wr_en, fb_wr_addr, fb_wr_data, i); end
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    checks++; if ({clear_done, fb_wr_en} !== 2'b10) begin errors++; $display("FAIL clr_done got=%b/%b want=1/0", clear_done, fb_wr_en); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    checks++; if ({clear_done, busy} !== 2'b00) begin errors++; $display("FAIL clr_after got=%b/%b want=0/0", clear_done, busy); end
  endtask

  task automatic test_clear_order();
    int n;
    cyc(0, 1, 1, 0, 8'h11, 1, 8'h22);
    checks++; if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 4'd1, 8'h11})
      begin errors++; $display("FAIL ord_cpu got=%b/%0d/%0h want=1/1/11", fb_wr_en, fb_wr_addr, fb_wr_data); end
    n = 0;
    do begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end while (fb_wr_en !== 1'b1 && n < 5);
    checks++; if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 4'd0, 8'h22})
      begin errors++; $display("FAIL ord_fill got=%b/%0d/%0h want=1/0/22", fb_wr_en, fb_wr_addr, fb_wr_data); end
    n = 0;
    while (clear_done !== 1'b1 && n < 20) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL ord_done got=no_pulse want=pulse"); end
  endtask

  task automatic test_clear_overflow();
    int n, got;
    cyc(0, 0, 0, 0, 0, 1, 8'h33);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, i % 4, i / 4, 8'hA0 + i, 0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
    n = 0;
    while (clear_done !== 1'b1 && n < 20) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
    checks++; if (n >= 20) begin errors++; $display("FAIL ovf_done got=no_pulse want=pulse"); end
    got = 0;
    for (int c = 0; c < 8; c++) begin
      if (fb_wr_en === 1'b1 && got < 6) begin
        checks++;
        if ({fb_wr_addr, fb_wr_data} !== {4'(got), 8'(8'hA0 + got)})
          begin errors++; $display("FAIL ovf_drain%0d got=%0d/%0h want=%0d/%0h", got, fb_wr_addr, fb_wr_data, got, 8'hA0 + got); end
        got++;
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
    end
    checks++; if (got !== 4) begin errors++; $display("FAIL ovf_count got=%0d want=4", got); end
    checks++; if ({overflow, busy} !== 2'b10) begin errors++; $display("FAIL ovf_sticky got=%b/%b want=1/0", overflow, busy); end
  endtask

  task automatic test_reset_during_clear();
    int n, pulses, writes;
    cyc(0, 0, 0, 0, 0, 1, 8'h44);
    n = 0;
    while (!(fb_wr_en === 1'b1 && fb_wr_addr === 4'd5) && n < 12) begin cyc(0, 0, 0, 0, 0, 0, 0); n++; end
    checks++; if (n >= 12) begin errors++; $display("FAIL rdc_reach got=no_addr5 want=addr5"); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({fb_wr_en, fb_wr_addr, fb_wr_data, busy, clear_done, overflow} !== 16'd0)
      begin errors++; $display("FAIL rdc_zero got=%b/%0d/%0h/%b/%b/%b want=all_zero", fb_wr_en, fb_wr_addr, fb_wr_data, busy, clear_done, overflow); end
    pulses = 0; writes = 0;
    for (int c = 0; c < 15; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (clear_done === 1'b1) pulses++;
      if (fb_wr_en === 1'b1) writes++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rdc_nodone got=%0d want=0", pulses); end
    checks++; if (writes !== 0) begin errors++; $display("FAIL rdc_nofill got=%0d want=0", writes); end
    cyc(0, 1, 2, 1, 8'h77, 0, 0);
    checks++; if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 4'd6, 8'h77})
      begin errors++; $display("FAIL rdc_bypass got=%b/%0d/%0h want=1/6/77", fb_wr_en, fb_wr_addr, fb_wr_data); end
  endtask
`else
  task automatic test_clear_ignored();
    int writes;
    cyc(0, 0, 0, 0, 0, 1, 8'h55);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got=%b want=0", busy); end
    writes = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (fb_wr_en === 1'b1 || clear_done === 1'b1) writes++;
    end
    checks++; if (writes !== 0) begin errors++; $display("FAIL ign_activity got=%0d want=0", writes); end
  endtask
`endif

  task automatic test_random();
    bit r, en, cs;
    int px, py, pv, pcv;
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 149) == 0);
      en  = ($urandom_range(0, 9) < 6);
      px  = $urandom_range(0, 3);
      py  = $urandom_range(0, 3);
      pv  = $urandom_range(0, 255);
      cs  = ($urandom_range(0, 24) == 0);
      pcv = $urandom_range(0, 255);
      cyc(r, en, px, py, pv, cs, pcv);
      checks++; if (fb_wr_en !== exp_en) begin errors++; $display("FAIL rnd_en cyc=%0d got=%b want=%b", i, fb_wr_en, exp_en); end
      checks++; if ({fb_wr_addr, fb_wr_data} !== {exp_addr, exp_data})
        begin errors++; $display("FAIL rnd_wr cyc=%0d got=%0d/%0h want=%0d/%0h", i, fb_wr_addr, fb_wr_data, exp_addr, exp_data); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b want=%b", i, busy, exp_busy); end
      checks++; if (clear_done !== exp_done) begin errors++; $display("FAIL rnd_done cyc=%0d got=%b want=%b", i, clear_done, exp_done); end
      checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got=%b want=%b", i, overflow, exp_ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_out_of_range();
`ifdef FB_CLEAR_EN
    test_clear();
    test_clear_order();
    test_clear_overflow();
    test_reset_during_clear();
`else
    test_clear_ignored();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
